// File: rtl/simd_scoreboard.sv
// Per-register countdown scoreboard for a vector pipeline, with an optional bypass window and a flush that squashes the youngest slots.
// stall/issue_fire/fwd_sel are combinational from the issue inputs; busy_vec/stall_cycles are registered. stall holds decode until every source can be read or bypassed.
module simd_scoreboard #(
    parameter int regQuantity = 16,
    parameter int selBits     = 4,
    parameter int PIPE_DEPTH  = 3,
    parameter int FWD_LIMIT   = 0,
    parameter int FLUSH_SLOTS = 1,
    localparam int cntW       = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    input  logic [selBits-1:0]     issue_rs1,
    input  logic [selBits-1:0]     issue_rs2,
    input  logic                   issue_uses_rs1,
    input  logic                   issue_uses_rs2,
    input  logic                   issue_wr_en,
    input  logic [selBits-1:0]     issue_rd,
    input  logic                   flush,
    output logic                   stall,
    output logic                   issue_fire,
    output logic [cntW-1:0]        fwd_sel1,
    output logic [cntW-1:0]        fwd_sel2,
    output logic [regQuantity-1:0] busy_vec,
    output logic [15:0]            stall_cycles
);

    localparam logic [cntW-1:0] C_DEPTH = cntW'(PIPE_DEPTH);
    localparam logic [cntW-1:0] C_FWD   = cntW'(FWD_LIMIT);
    localparam logic [cntW-1:0] C_FLUSH = cntW'(PIPE_DEPTH - FLUSH_SLOTS);

    if (regQuantity > (1 << selBits) || FWD_LIMIT >= PIPE_DEPTH ||
        FLUSH_SLOTS < 1 || FLUSH_SLOTS > PIPE_DEPTH) begin : g_bad_params
        $error("simd_scoreboard: illegal parameter combination");
    end

    logic [cntW-1:0]        r_cnt [regQuantity];
    logic [cntW-1:0]        w_cnt_nxt [regQuantity];
    logic [regQuantity-1:0] r_busy_vec;
    logic [15:0]            r_stall_cycles;
    logic [cntW-1:0]        w_src1_cnt;
    logic [cntW-1:0]        w_src2_cnt;
    logic [cntW-1:0]        w_fwd1;
    logic [cntW-1:0]        w_fwd2;
    logic                   w_hz1;
    logic                   w_hz2;
    logic                   w_stall;
    logic                   w_fire;
    logic                   w_load;

    // Selects that match no tracked register leave the count at 0.
    always_comb begin
        w_src1_cnt = '0;
        w_src2_cnt = '0;
        for (int r = 0; r < regQuantity; r++) begin
            if (issue_rs1 == selBits'(r)) w_src1_cnt = r_cnt[r];
            if (issue_rs2 == selBits'(r)) w_src2_cnt = r_cnt[r];
        end
    end

    assign w_hz1   = issue_uses_rs1 && (w_src1_cnt > C_FWD);
    assign w_hz2   = issue_uses_rs2 && (w_src2_cnt > C_FWD);
    assign w_stall = rst && issue_valid && (w_hz1 || w_hz2) && !flush;
    assign w_fire  = rst && issue_valid && !(w_hz1 || w_hz2) && !flush;
    assign w_load  = w_fire && issue_wr_en;

    always_comb begin
        w_fwd1 = '0;
        w_fwd2 = '0;
        if (FWD_LIMIT > 0 && rst) begin
            if (issue_uses_rs1 && w_src1_cnt != '0 && w_src1_cnt <= C_FWD) w_fwd1 = w_src1_cnt;
            if (issue_uses_rs2 && w_src2_cnt != '0 && w_src2_cnt <= C_FWD) w_fwd2 = w_src2_cnt;
        end
    end

    // Flush wins over the load; the load wins over the decrement.
    always_comb begin
        for (int r = 0; r < regQuantity; r++) begin
            w_cnt_nxt[r] = (r_cnt[r] != '0) ? r_cnt[r] - cntW'(1) : '0;
            if (flush && r_cnt[r] > C_FLUSH)
                w_cnt_nxt[r] = '0;
            else if (w_load && issue_rd == selBits'(r))
                w_cnt_nxt[r] = C_DEPTH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < regQuantity; r++) r_cnt[r] <= '0;
            r_busy_vec     <= '0;
            r_stall_cycles <= '0;
        end else begin
            for (int r = 0; r < regQuantity; r++) begin
                r_cnt[r]      <= w_cnt_nxt[r];
                r_busy_vec[r] <= (w_cnt_nxt[r] != '0);
            end
            if (w_stall && r_stall_cycles != 16'hFFFF)
                r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall        = w_stall;
    assign issue_fire   = w_fire;
    assign fwd_sel1     = w_fwd1;
    assign fwd_sel2     = w_fwd2;
    assign busy_vec     = r_busy_vec;
    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_simd_scoreboard.sv
// Bench for simd_scoreboard: timestamp model for the default instance, literal checks for bypass and saturation instances.
module tb_simd_scoreboard;

    localparam int QTY = 16;
    localparam int PD  = 3;
    localparam int FL  = 0;
    localparam int FS  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       iv, u1, u2, wr, fl;
    logic [3:0] rs1, rs2, rd;

    logic        d_stall, d_fire;
    logic [1:0]  d_f1, d_f2;
    logic [15:0] d_busy, d_sc;
    logic        f_stall, f_fire;
    logic [1:0]  f_f1, f_f2;
    logic [15:0] f_busy, f_sc;

    logic        s_iv;
    logic [3:0]  s_reg;
    logic        s_zero;
    logic        s_stall, s_fire;
    logic [3:0]  s_f1, s_f2;
    logic [15:0] s_busy, s_sc;

    simd_scoreboard u_dut (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_rs1(rs1), .issue_rs2(rs2),
        .issue_uses_rs1(u1), .issue_uses_rs2(u2), .issue_wr_en(wr), .issue_rd(rd),
        .flush(fl), .stall(d_stall), .issue_fire(d_fire), .fwd_sel1(d_f1), .fwd_sel2(d_f2),
        .busy_vec(d_busy), .stall_cycles(d_sc)
    );

    simd_scoreboard #(.FWD_LIMIT(2)) u_fwd (
        .clk(clk), .rst(rst), .issue_valid(iv), .issue_rs1(rs1), .issue_rs2(rs2),
        .issue_uses_rs1(u1), .issue_uses_rs2(u2), .issue_wr_en(wr), .issue_rd(rd),
        .flush(fl), .stall(f_stall), .issue_fire(f_fire), .fwd_sel1(f_f1), .fwd_sel2(f_f2),
        .busy_vec(f_busy), .stall_cycles(f_sc)
    );

    simd_scoreboard #(.PIPE_DEPTH(15)) u_sat (
        .clk(clk), .rst(rst), .issue_valid(s_iv), .issue_rs1(s_reg), .issue_rs2(s_reg),
        .issue_uses_rs1(s_iv), .issue_uses_rs2(s_zero), .issue_wr_en(s_iv), .issue_rd(s_reg),
        .flush(s_zero), .stall(s_stall), .issue_fire(s_fire), .fwd_sel1(s_f1), .fwd_sel2(s_f2),
        .busy_vec(s_busy), .stall_cycles(s_sc)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each register remembers the cycle its result lands in the register file.
    int ra [QTY];
    int m_sc = 0;

    function automatic int rem(input int r);
        return (ra[r] > cyc) ? ra[r] - cyc : 0;
    endfunction

    always @(negedge clk) begin
        int c1, c2, e_f1, e_f2;
        bit h1, h2, e_st, e_fi;
        logic [15:0] e_busy;
        c1 = u1 ? rem(int'(rs1)) : 0;
        c2 = u2 ? rem(int'(rs2)) : 0;
        h1 = c1 > FL;
        h2 = c2 > FL;
        e_st = rst && iv && (h1 || h2) && !fl;
        e_fi = rst && iv && !(h1 || h2) && !fl;
        e_f1 = (rst && c1 > 0 && c1 <= FL) ? c1 : 0;
        e_f2 = (rst && c2 > 0 && c2 <= FL) ? c2 : 0;
        for (int r = 0; r < QTY; r++) e_busy[r] = (rem(r) != 0);
        if (chk_en) begin
            check("stall", 32'(d_stall), 32'(e_st));
            check("issue_fire", 32'(d_fire), 32'(e_fi));
            check("fwd_sel1", 32'(d_f1), e_f1);
            check("fwd_sel2", 32'(d_f2), e_f2);
            check("busy_vec", 32'(d_busy), 32'(e_busy));
            check("stall_cycles", 32'(d_sc), m_sc);
        end
        if (!rst) begin
            for (int r = 0; r < QTY; r++) ra[r] = 0;
            m_sc = 0;
        end else begin
            if (e_st && m_sc < 65535) m_sc++;
            if (fl) begin
                for (int r = 0; r < QTY; r++) if (rem(r) > PD - FS) ra[r] = 0;
            end else if (e_fi && wr) begin
                ra[int'(rd)] = cyc + 1 + PD;
            end
        end
        cyc++;
    end

    task automatic drive(input logic v, input int a, input logic ua, input int b,
                         input logic ub, input logic w, input int d, input logic f);
        iv = v; rs1 = 4'(a); u1 = ua; rs2 = 4'(b); u2 = ub; wr = w; rd = 4'(d); fl = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b0; s_iv = 1'b0; s_reg = 4'd0; s_zero = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk_en = 1'b1;

        // Reset forces the combinational outputs low even with a valid write presented.
        drive(1, 0, 0, 0, 0, 1, 9, 0);
        @(negedge clk);
        check("rst_fire", 32'(d_fire), 0);
        check("rst_busy", 32'(d_busy), 0);
        check("rst_sc", 32'(d_sc), 0);
        tick();
        rst = 1'b1;
        idle(1);

        // Producer r3 then dependent read of r3, held until the default instance issues.
        drive(1, 0, 0, 0, 0, 1, 3, 0);
        @(negedge clk); check("A_T_fire", 32'(d_fire), 1); check("A_T_ffire", 32'(f_fire), 1);
        tick();
        drive(1, 3, 1, 0, 0, 0, 0, 0);
        @(negedge clk); check("A_T1_stall", 32'(d_stall), 1); check("A_T1_fstall", 32'(f_stall), 1);
        tick();
        @(negedge clk); check("A_T2_stall", 32'(d_stall), 1); check("A_T2_fstall", 32'(f_stall), 0);
        check("A_T2_ffire", 32'(f_fire), 1); check("A_T2_ffwd1", 32'(f_f1), 2);
        check("A_T2_ffwd2", 32'(f_f2), 0);
        tick();
        @(negedge clk); check("A_T3_stall", 32'(d_stall), 1); check("A_T3_ffwd1", 32'(f_f1), 1);
        check("A_T3_ffire", 32'(f_fire), 1);
        tick();
        @(negedge clk); check("A_T4_stall", 32'(d_stall), 0); check("A_T4_fire", 32'(d_fire), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("A_sc", 32'(d_sc), 3); check("A_fsc", 32'(f_sc), 1);
        check("A_fbusy", 32'(f_busy), 0);
        tick();

        // Write r5, flush the next cycle: the young write is squashed.
        drive(1, 0, 0, 0, 0, 1, 5, 0); tick();
        drive(1, 5, 1, 0, 0, 0, 0, 1);
        @(negedge clk); check("B_fl_stall", 32'(d_stall), 0); check("B_fl_fire", 32'(d_fire), 0);
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0);
        @(negedge clk); check("B_busy5", 32'(d_busy[5]), 0); check("B_stall", 32'(d_stall), 0);
        check("B_fire", 32'(d_fire), 1);
        tick();
        idle(3);

        // An older write survives a flush and keeps decrementing.
        drive(1, 0, 0, 0, 0, 1, 8, 0); tick();
        idle(1);
        drive(0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); check("Fb_busy8_1", 32'(d_busy[8]), 1); tick();
        @(negedge clk); check("Fb_busy8_0", 32'(d_busy[8]), 0); tick();

        // Back-to-back writes to r2 never stall.
        drive(1, 0, 0, 0, 0, 1, 2, 0);
        @(negedge clk); check("C_T_fire", 32'(d_fire), 1); tick();
        @(negedge clk); check("C_T1_fire", 32'(d_fire), 1); check("C_T1_stall", 32'(d_stall), 0);
        tick();
        idle(2);
        @(negedge clk); check("C_busy2_T4", 32'(d_busy[2]), 1); tick();
        @(negedge clk); check("C_busy2_T5", 32'(d_busy[2]), 0); tick();

        // Read and write the same register: only the old count matters.
        drive(1, 7, 1, 7, 1, 1, 7, 0);
        @(negedge clk); check("D_T_fire", 32'(d_fire), 1); tick();
        @(negedge clk); check("D_T1_stall", 32'(d_stall), 1); tick();
        tick(); tick();
        @(negedge clk); check("D_T4_fire", 32'(d_fire), 1); tick();
        idle(4);

        // rs2 hazard only counts when the source is used.
        drive(1, 0, 0, 0, 0, 1, 10, 0); tick();
        drive(1, 0, 0, 10, 0, 0, 0, 0);
        @(negedge clk); check("G_nouse_fire", 32'(d_fire), 1); tick();
        drive(1, 0, 0, 10, 1, 0, 0, 0);
        @(negedge clk); check("G_use_stall", 32'(d_stall), 1); tick();
        idle(4);

        // Three writes pending, then a one-cycle reset.
        drive(1, 0, 0, 0, 0, 1, 1, 0); tick();
        drive(1, 0, 0, 0, 0, 1, 2, 0); tick();
        drive(1, 0, 0, 0, 0, 1, 4, 0); tick();
        rst = 1'b0;
        drive(1, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); check("E_rst_stall", 32'(d_stall), 0); check("E_rst_fire", 32'(d_fire), 0);
        tick();
        rst = 1'b1;
        @(negedge clk); check("E_busy", 32'(d_busy), 0); check("E_stall", 32'(d_stall), 0);
        check("E_fire", 32'(d_fire), 1); check("E_sc", 32'(d_sc), 0);
        tick();
        idle(2);

        // Saturation: self-dependent instruction on a deep pipe stalls 15 of every 16 cycles.
        s_iv = 1'b1;
        repeat (70000) tick();
        @(negedge clk);
        check("S_sc_sat", 32'(s_sc), 32'hFFFF);
        check("S_fwd1", 32'(s_f1), 0);
        check("S_fwd2", 32'(s_f2), 0);
        check("S_busy_hi", 32'(s_busy & 16'hFFFE), 0);
        tick();
        s_iv = 1'b0;
        repeat (16) tick();
        @(negedge clk);
        check("S_idle_stall", 32'(s_stall), 0);
        check("S_idle_fire", 32'(s_fire), 0);
        check("S_idle_busy", 32'(s_busy), 0);
        check("S_sc_hold", 32'(s_sc), 32'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/simd_scoreboard.md
SIMD_SCOREBOARD -- requirements
Module: simd_scoreboard

Interface
REQ-001 Parameter regQuantity, default 16, number of architectural vector registers tracked.
REQ-002 Parameter selBits, default 4, register-select width; regQuantity SHALL be at most 2**selBits.
REQ-003 Parameter PIPE_DEPTH, default 3, cycles from issue until the result is in the register file.
REQ-004 Parameter FWD_LIMIT, default 0, highest remaining-count value the bypass network covers; 0 means no forwarding; FWD_LIMIT SHALL be less than PIPE_DEPTH.
REQ-005 Parameter FLUSH_SLOTS, default 1, number of youngest issue slots squashed by flush; range 1..PIPE_DEPTH.
REQ-006 Derived cntW = clog2(PIPE_DEPTH+1).
REQ-007 clk  in  1  sole clock; all state updates on rising edge.
REQ-008 rst  in  1  synchronous, active-low reset.
REQ-009 issue_valid  in  1  decode presents an instruction.
REQ-010 issue_rs1, issue_rs2  in  selBits each  source register selects.
REQ-011 issue_uses_rs1, issue_uses_rs2  in  1 each  the source is actually read.
REQ-012 issue_wr_en  in  1  the instruction writes a register.
REQ-013 issue_rd  in  selBits  destination register.
REQ-014 flush  in  1  taken PC write; squash the youngest FLUSH_SLOTS slots.
REQ-015 stall  out  1  hold fetch/decode; combinational.
REQ-016 issue_fire  out  1  instruction accepted this cycle; combinational.
REQ-017 fwd_sel1, fwd_sel2  out  cntW each  0 = read register file; otherwise the remaining count of the producer to bypass from.
REQ-018 busy_vec  out  regQuantity  bit r = (cnt[r] != 0); registered.
REQ-019 stall_cycles  out  16  saturating count of stalled cycles; registered.

Function
REQ-020 One counter cnt[r] of width cntW SHALL be kept per register.
REQ-021 hz1 = issue_uses_rs1 and cnt[issue_rs1] > FWD_LIMIT; hz2 is defined the same way for rs2.
REQ-022 stall = issue_valid and (hz1 or hz2) and not flush.
REQ-023 issue_fire = issue_valid and not stall and not flush.
REQ-024 fwd_selN = cnt[issue_rsN] when issue_uses_rsN and 0 < cnt[issue_rsN] <= FWD_LIMIT; otherwise 0.
REQ-025 With FWD_LIMIT = 0, fwd_sel1 and fwd_sel2 SHALL be constant 0.
REQ-026 Each cycle every nonzero cnt[r] SHALL decrement by 1; a counter at 0 stays at 0 and never wraps.
REQ-027 When issue_fire and issue_wr_en, cnt[issue_rd] SHALL load PIPE_DEPTH; the load overrides the decrement of that entry.
REQ-028 A write-after-write to a busy register SHALL simply reload that register's counter and SHALL NOT stall.
REQ-029 A read-after-write with rd equal to rs in the same instruction SHALL check only the old count; the new load becomes visible next cycle.
REQ-030 When flush = 1, every cnt[r] > PIPE_DEPTH - FLUSH_SLOTS SHALL clear to 0 and all others decrement; there is no issue load that cycle.
REQ-031 Out-of-range selects (value >= regQuantity) SHALL read as count 0 and SHALL load nothing.
REQ-032 stall_cycles SHALL increment when stall = 1 and hold at 16'hFFFF.
REQ-033 Issue-to-dependent spacing: a producer issued at cycle T lets a dependent issue at T+k, for the smallest k with PIPE_DEPTH-k+1 <= FWD_LIMIT.

Reset
REQ-034 While rst = 0 at a clock edge, all cnt, busy_vec and stall_cycles SHALL become 0.
REQ-035 During reset, stall and issue_fire SHALL be forced to 0, and fwd_sel1 and fwd_sel2 to 0.
REQ-036 Reset asserted mid-operation SHALL discard all pending hazards with no residual stall after release.

Verification
REQ-037 Defaults: issue r3 write at T, dependent reads r3 from T+1 -> stall=1 at T+1..T+3, issue_fire=1 at T+4, stall_cycles=3.
REQ-038 FWD_LIMIT=2: same stimulus -> stall only at T+1; at T+2 fwd_sel1=2; if still issuing at T+3, fwd_sel1=1.
REQ-039 Issue r5 write, flush next cycle -> cnt[r5] cleared, busy_vec[5]=0, and a following r5 read issues without stall.
REQ-040 r2 written at T and again at T+1 (no source use) -> no stall; busy_vec[2] clears at T+5.
REQ-041 Hold stall for 70000 cycles -> stall_cycles saturates at 65535.
REQ-042 Three writes pending, then rst=0 for 1 cycle -> busy_vec=0, stall=0 on the first cycle after release.
